ifu_fetch_ctrl: RTL

IFU_FETCH_CTRL -- requirements
Module: ifu_fetch_ctrl

---
 rtl/ifu_fetch_ctrl_if.sv | 44 ++++
 rtl/ifu_fetch_ctrl.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/ifu_fetch_ctrl_if.sv
// Fetch-controller bundle: instruction-memory request/ack, decode handoff,
// redirect input and the sticky alignment-error flag.
// "master" is the fetch controller side; "slave" is the memory/decode environment.
interface ifu_fetch_ctrl_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        addr_err;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata,
        output instr,
        output instr_pc,
        output instr_valid,
        input  instr_ready,
        input  redirect_valid,
        input  redirect_pc,
        output addr_err
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata,
        input  instr,
        input  instr_pc,
        input  instr_valid,
        output instr_ready,
        output redirect_valid,
        output redirect_pc,
        input  addr_err
    );
endinterface

// File: rtl/ifu_fetch_ctrl.sv
// ifu_fetch_ctrl: single-outstanding instruction fetch controller.
// Sequence is IDLE -> REQ (wait for ack) -> VALID (wait for decode) -> REQ ...
// Redirects seen while a request is in flight are parked in a pending
// register and applied when the in-flight word returns (that word is dropped).
// Optional feature macro: IFU_ALIGN_CHECK_EN -- when defined, a misaligned
// redirect target sets a sticky addr_err and parks the FSM in HALT until reset;
// when undefined, target bits [1:0] are forced to zero and addr_err is 0.
module ifu_fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h00003000
) (
    input  logic              clk,
    input  logic              reset,
    ifu_fetch_ctrl_if.master  bus
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_REQ   = 2'd1;
    localparam logic [1:0] S_VALID = 2'd2;
`ifdef IFU_ALIGN_CHECK_EN
    localparam logic [1:0] S_HALT  = 2'd3;
`endif

    logic [1:0]  state_reg, state_next;
    logic [31:0] pc_reg, pc_next;
    logic        pend_valid_reg, pend_valid_next;
    logic [31:0] pend_pc_reg, pend_pc_next;
    logic [31:0] instr_reg, instr_next;
    logic [31:0] instr_pc_reg, instr_pc_next;

    logic [31:0] redir_tgt;     // redirect target after optional alignment forcing
    logic        redir_misal;   // current redirect target is misaligned
    logic        take_pend;     // ack in REQ must be discarded in favour of a target
    logic [31:0] pend_tgt;      // target applied on that discarding ack
    logic        pend_misal;    // that target is misaligned

`ifdef IFU_ALIGN_CHECK_EN
    logic        addr_err_reg, addr_err_next;

    // Targets pass through untouched so misalignment can be detected.
    always_comb begin
        redir_tgt   = bus.redirect_pc;
        redir_misal = |bus.redirect_pc[1:0];
    end
`else
    logic        unused_low_bits;

    // Targets are silently word-aligned; misalignment cannot occur.
    always_comb begin
        redir_tgt   = {bus.redirect_pc[31:2], 2'b00};
        redir_misal = 1'b0;
    end

    assign unused_low_bits = &{1'b0, bus.redirect_pc[1:0]};
`endif

    // Select the target applied when the in-flight word comes back: a redirect
    // arriving on the ack cycle itself overrides an older pending one.
    always_comb begin
        take_pend  = pend_valid_reg | bus.redirect_valid;
        pend_tgt   = bus.redirect_valid ? redir_tgt : pend_pc_reg;
        pend_misal = bus.redirect_valid ? redir_misal : (|pend_pc_reg[1:0]);
    end

    // Next-state and datapath update for each fetch phase.
    always_comb begin
        state_next      = state_reg;
        pc_next         = pc_reg;
        pend_valid_next = pend_valid_reg;
        pend_pc_next    = pend_pc_reg;
        instr_next      = instr_reg;
        instr_pc_next   = instr_pc_reg;
`ifdef IFU_ALIGN_CHECK_EN
        addr_err_next   = addr_err_reg;
`endif
        case (state_reg)
            S_IDLE: begin
                // A redirect here is kept so it is not lost before the first request.
                if (bus.redirect_valid) begin
                    pend_valid_next = 1'b1;
                    pend_pc_next    = redir_tgt;
                end
                state_next = S_REQ;
            end
            S_REQ: begin
                if (bus.imem_ack) begin
                    if (take_pend) begin
                        // Returned word belongs to a stale path: drop it and refetch.
                        pend_valid_next = 1'b0;
`ifdef IFU_ALIGN_CHECK_EN
                        if (pend_misal) begin
                            addr_err_next = 1'b1;
                            state_next    = S_HALT;
                        end else begin
                            pc_next = pend_tgt;
                        end
`else
                        pc_next = pend_tgt;
`endif
                    end else begin
                        instr_next    = bus.imem_rdata;
                        instr_pc_next = pc_reg;
                        state_next    = S_VALID;
                    end
                end else if (bus.redirect_valid) begin
                    // imem_addr must stay put until ack, so only remember the target.
                    pend_valid_next = 1'b1;
                    pend_pc_next    = redir_tgt;
                end
            end
            S_VALID: begin
                if (bus.redirect_valid) begin
                    // Redirect wins over a simultaneous decode accept.
`ifdef IFU_ALIGN_CHECK_EN
                    if (redir_misal) begin
                        addr_err_next = 1'b1;
                        state_next    = S_HALT;
                    end else begin
                        pc_next    = redir_tgt;
                        state_next = S_REQ;
                    end
`else
                    pc_next    = redir_tgt;
                    state_next = S_REQ;
`endif
                end else if (bus.instr_ready) begin
                    pc_next    = pc_reg + 32'd4;
                    state_next = S_REQ;
                end
            end
`ifdef IFU_ALIGN_CHECK_EN
            S_HALT: begin
                state_next = S_HALT;
            end
`endif
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Register update; reset takes precedence over any in-flight activity.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= S_IDLE;
            pc_reg         <= RESET_PC;
            pend_valid_reg <= 1'b0;
            pend_pc_reg    <= 32'd0;
            instr_reg      <= 32'd0;
            instr_pc_reg   <= 32'd0;
`ifdef IFU_ALIGN_CHECK_EN
            addr_err_reg   <= 1'b0;
`endif
        end else begin
            state_reg      <= state_next;
            pc_reg         <= pc_next;
            pend_valid_reg <= pend_valid_next;
            pend_pc_reg    <= pend_pc_next;
            instr_reg      <= instr_next;
            instr_pc_reg   <= instr_pc_next;
`ifdef IFU_ALIGN_CHECK_EN
            addr_err_reg   <= addr_err_next;
`endif
        end
    end

    // Outputs are decoded from registered state only, so imem_addr is stable
    // for the whole REQ phase.
    assign bus.imem_req    = (state_reg == S_REQ);
    assign bus.imem_addr   = pc_reg;
    assign bus.instr_valid = (state_reg == S_VALID);
    assign bus.instr       = instr_reg;
    assign bus.instr_pc    = instr_pc_reg;
`ifdef IFU_ALIGN_CHECK_EN
    assign bus.addr_err    = addr_err_reg;
`else
    assign bus.addr_err    = 1'b0;
`endif

endmodule
